// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares the single-port RAM between flash programming, fetch and load/store
module mem_port_arbiter #(
  parameter int WIDTH       = 32,
  parameter int ADDR_WIDTH  = 11,
  parameter int HOLD_CYCLES = 4,
  parameter int MAX_WAIT    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flash_en,
  input  logic [WIDTH-1:0]      flash_addr,
  input  logic [WIDTH-1:0]      flash_data,
  input  logic                  if_req,
  input  logic [WIDTH-1:0]      if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [WIDTH-1:0]      if_rdata,
  input  logic                  dm_req,
  input  logic                  dm_we,
  input  logic [WIDTH-1:0]      dm_addr,
  input  logic [WIDTH-1:0]      dm_wdata,
  output logic                  dm_gnt,
  output logic                  dm_rvalid,
  output logic [WIDTH-1:0]      dm_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-3:0] mem_addr,
  output logic [WIDTH-1:0]      mem_wdata,
  input  logic [WIDTH-1:0]      mem_rdata,
  output logic                  core_hold
);

  // Quiet counter must be able to hold HOLD_CYCLES itself; wait counter saturates at MAX_WAIT.
  localparam int QW = $clog2(HOLD_CYCLES + 1);
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [QW-1:0] HOLD_VAL = QW'(HOLD_CYCLES);
  localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

  typedef enum logic {
    PROG = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2
  } owner_t;

  state_t         state_q, state_d;
  logic [QW-1:0]  quiet_q, quiet_d;
  logic [QW-1:0]  quiet_inc;
  logic [WW-1:0]  wait_q, wait_d;
  owner_t         owner_q, owner_d;
  logic           run;
  logic           fetch_first;

  // Only the word-index bits of each address reach the RAM; the rest alias away.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{flash_addr[WIDTH-1:ADDR_WIDTH], flash_addr[1:0],
                              if_addr[WIDTH-1:ADDR_WIDTH], if_addr[1:0],
                              dm_addr[WIDTH-1:ADDR_WIDTH], dm_addr[1:0]};

  assign run       = (state_q == RUN);
  assign core_hold = (state_q == PROG);
  assign quiet_inc = quiet_q + QW'(1);

  // Fetch wins when data is idle or when fetch has been starved for MAX_WAIT cycles.
  assign fetch_first = if_req && (!dm_req || (wait_q == WAIT_MAX));
  assign if_gnt      = run && !flash_en && fetch_first;
  assign dm_gnt      = run && !flash_en && dm_req && !fetch_first;

  // Read data is shared; rvalid alone says whose it is. Reset kills a pending response at once.
  assign if_rdata  = mem_rdata;
  assign dm_rdata  = mem_rdata;
  assign if_rvalid = rst && (owner_q == OWN_IF);
  assign dm_rvalid = rst && (owner_q == OWN_DM);

  // RAM port mux: flash always preempts, otherwise the single granted core requester.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (flash_en) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = flash_addr[ADDR_WIDTH-1:2];
      mem_wdata = flash_data;
    end else if (if_gnt) begin
      mem_en    = 1'b1;
      mem_addr  = if_addr[ADDR_WIDTH-1:2];
    end else if (dm_gnt) begin
      mem_en    = 1'b1;
      mem_we    = dm_we;
      mem_addr  = dm_addr[ADDR_WIDTH-1:2];
      mem_wdata = dm_wdata;
    end
  end

  // Next-state logic: program/run mode, quiet period, starvation counter and response owner.
  always_comb begin
    state_d = state_q;
    quiet_d = quiet_q;
    wait_d  = wait_q;
    owner_d = OWN_NONE;

    case (state_q)
      PROG: begin
        wait_d = '0;
        if (flash_en) begin
          quiet_d = '0;
        end else begin
          quiet_d = quiet_inc;
          if (quiet_inc == HOLD_VAL) begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (flash_en) begin
          state_d = PROG;
          quiet_d = '0;
        end
        if (!if_req || if_gnt) begin
          wait_d = '0;
        end else if (wait_q != WAIT_MAX) begin
          wait_d = wait_q + WW'(1);
        end
      end
      default: begin
        state_d = PROG;
        quiet_d = '0;
        wait_d  = '0;
      end
    endcase

    if (if_gnt) begin
      owner_d = OWN_IF;
    end else if (dm_gnt && !dm_we) begin
      owner_d = OWN_DM;
    end
  end

  // State register; reset parks the core in PROG with no response pending.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= PROG;
      quiet_q <= '0;
      wait_q  <= '0;
      owner_q <= OWN_NONE;
    end else begin
      state_q <= state_d;
      quiet_q <= quiet_d;
      wait_q  <= wait_d;
      owner_q <= owner_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;
  localparam int WIDTH = 32;
  localparam int AW    = 11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, flash_en, if_req, dm_req, dm_we;
  logic [WIDTH-1:0]  flash_addr, flash_data, if_addr, dm_addr, dm_wdata;
  logic              if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_en, mem_we, core_hold;
  logic [WIDTH-1:0]  if_rdata, dm_rdata, mem_wdata, mem_rdata;
  logic [AW-3:0]     mem_addr;

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] ram     [0:511];
  logic [31:0] ref_mem [0:511];

  typedef struct packed {
    logic        iv;
    logic        dv;
    logic [31:0] d;
  } resp_t;
  resp_t exp_q[$];
  resp_t mon_e;
  logic  mon_en = 1'b0;

  mem_port_arbiter #(.WIDTH(WIDTH), .ADDR_WIDTH(AW), .HOLD_CYCLES(4), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .flash_en(flash_en), .flash_addr(flash_addr), .flash_data(flash_data),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .core_hold(core_hold)
  );

  // RAM fixture: synchronous single port, read data one cycle after the access
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end
  end

  // Scoreboard: each cycle pops the response expected from the previous cycle's grant
  always begin
    @(posedge clk);
    #2;
    if (mon_en) begin
      if (exp_q.size() > 0) mon_e = exp_q.pop_front();
      else mon_e = '0;
      tests_run++;
      if (if_rvalid !== mon_e.iv) begin
        tests_failed++;
        $display("FAIL sb_if_rvalid t=%0t got %b exp %b", $time, if_rvalid, mon_e.iv);
      end
      tests_run++;
      if (dm_rvalid !== mon_e.dv) begin
        tests_failed++;
        $display("FAIL sb_dm_rvalid t=%0t got %b exp %b", $time, dm_rvalid, mon_e.dv);
      end
      if (mon_e.iv) begin
        tests_run++;
        if (if_rdata !== mon_e.d) begin
          tests_failed++;
          $display("FAIL sb_if_rdata t=%0t got %h exp %h", $time, if_rdata, mon_e.d);
        end
      end
      if (mon_e.dv) begin
        tests_run++;
        if (dm_rdata !== mon_e.d) begin
          tests_failed++;
          $display("FAIL sb_dm_rdata t=%0t got %h exp %h", $time, dm_rdata, mon_e.d);
        end
      end
    end
  end

  task automatic set_idle();
    flash_en = 1'b0;
    if_req   = 1'b0;
    dm_req   = 1'b0;
    dm_we    = 1'b0;
  endtask

  task automatic push_read(input logic is_if, input logic [31:0] addr);
    resp_t r;
    r.iv = is_if;
    r.dv = !is_if;
    r.d  = ref_mem[addr[10:2]];
    exp_q.push_back(r);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0; set_idle();
    if_req = 1'b1; if_addr = 32'h10; dm_req = 1'b1; dm_addr = 32'h20;
    #1;
    tests_run++;
    if ({core_hold, if_gnt, dm_gnt, if_rvalid, dm_rvalid, mem_en, mem_we} !== 7'b1000000) begin
      tests_failed++;
      $display("FAIL reset_flags got %b exp 1000000",
               {core_hold, if_gnt, dm_gnt, if_rvalid, dm_rvalid, mem_en, mem_we});
    end
    tests_run++;
    if (mem_addr !== '0 || mem_wdata !== '0) begin
      tests_failed++;
      $display("FAIL reset_mem_bus got addr %h data %h exp 0 0", mem_addr, mem_wdata);
    end
  endtask

  task automatic test_flash_during_reset();
    logic [31:0] fa [3];
    logic [31:0] fd [3];
    logic [31:0] ra [3];
    fa[0] = 32'd0;  fd[0] = 32'h02802783;
    fa[1] = 32'd36; fd[1] = 32'h00000005;
    fa[2] = 32'd16; fd[2] = 32'h0000006f;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      set_idle(); rst = 1'b0; if_req = 1'b1;
      flash_en = 1'b1; flash_addr = fa[i]; flash_data = fd[i];
      ref_mem[fa[i][10:2]] = fd[i];
      #1;
      tests_run++;
      if ({mem_en, mem_we, if_gnt, dm_gnt, core_hold} !== 5'b11001 ||
          mem_addr !== fa[i][10:2] || mem_wdata !== fd[i]) begin
        tests_failed++;
        $display("FAIL flash_rst_write%0d got en/we/ig/dg/hold %b addr %h data %h exp 11001 %h %h",
                 i, {mem_en, mem_we, if_gnt, dm_gnt, core_hold}, mem_addr, mem_wdata,
                 fa[i][10:2], fd[i]);
      end
    end
    @(negedge clk);
    set_idle(); rst = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      #1;
      tests_run++;
      if (core_hold !== ((k < 4) ? 1'b1 : 1'b0)) begin
        tests_failed++;
        $display("FAIL release_hold edge%0d got %b exp %b", k, core_hold, (k < 4) ? 1'b1 : 1'b0);
      end
    end
    ra[0] = 32'd0; ra[1] = 32'd16; ra[2] = 32'd36;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      set_idle(); if_req = 1'b1; if_addr = ra[i];
      #1;
      tests_run++;
      if ({if_gnt, dm_gnt, mem_en, mem_we} !== 4'b1010 || mem_addr !== ra[i][10:2]) begin
        tests_failed++;
        $display("FAIL fetch_readback%0d got gnt/en/we %b addr %h exp 1010 %h",
                 i, {if_gnt, dm_gnt, mem_en, mem_we}, mem_addr, ra[i][10:2]);
      end
      push_read(1'b1, ra[i]);
    end
    @(negedge clk);
    set_idle();
  endtask

  task automatic test_contention();
    logic exp_if;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      set_idle();
      if_req = 1'b1; if_addr = 32'd16;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'd36;
      exp_if = (i == 4 || i == 9);
      #1;
      tests_run++;
      if ({if_gnt, dm_gnt} !== {exp_if, !exp_if}) begin
        tests_failed++;
        $display("FAIL contention cyc%0d got if/dm %b exp %b", i, {if_gnt, dm_gnt}, {exp_if, !exp_if});
      end
      push_read(exp_if, exp_if ? 32'd16 : 32'd36);
    end
    @(negedge clk);
    set_idle();
  endtask

  task automatic test_store_load();
    @(negedge clk);
    set_idle(); dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h40; dm_wdata = 32'hDEADBEEF;
    ref_mem[16] = 32'hDEADBEEF;
    #1;
    tests_run++;
    if ({dm_gnt, if_gnt, mem_en, mem_we} !== 4'b1011 || mem_addr !== 9'd16 || mem_wdata !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("FAIL store got gnt/en/we %b addr %h data %h exp 1011 010 deadbeef",
               {dm_gnt, if_gnt, mem_en, mem_we}, mem_addr, mem_wdata);
    end
    @(negedge clk);
    set_idle(); dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h40;
    #1;
    tests_run++;
    if ({dm_gnt, mem_we} !== 2'b10) begin
      tests_failed++;
      $display("FAIL load_gnt got gnt/we %b exp 10", {dm_gnt, mem_we});
    end
    push_read(1'b0, 32'h40);
    @(negedge clk);
    set_idle();
  endtask

  task automatic test_alias();
    logic [31:0] aa [2];
    aa[0] = 32'h804; aa[1] = 32'h004;
    @(negedge clk);
    set_idle(); dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h4; dm_wdata = 32'h12345678;
    ref_mem[1] = 32'h12345678;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      set_idle(); if_req = 1'b1; if_addr = aa[i];
      #1;
      tests_run++;
      if (if_gnt !== 1'b1 || mem_addr !== 9'd1) begin
        tests_failed++;
        $display("FAIL alias%0d got gnt %b addr %h exp 1 001", i, if_gnt, mem_addr);
      end
      push_read(1'b1, aa[i]);
    end
    @(negedge clk);
    set_idle();
  endtask

  task automatic test_preempt();
    @(negedge clk);
    set_idle(); dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'd36;
    #1;
    tests_run++;
    if (dm_gnt !== 1'b1) begin
      tests_failed++;
      $display("FAIL preempt_setup got dm_gnt %b exp 1", dm_gnt);
    end
    push_read(1'b0, 32'd36);
    @(negedge clk);
    flash_en = 1'b1; flash_addr = 32'h80; flash_data = 32'hA5A5A5A5;
    #1;
    tests_run++;
    if ({if_gnt, dm_gnt, mem_we, core_hold} !== 4'b0010 || mem_addr !== 9'd32) begin
      tests_failed++;
      $display("FAIL preempt_cycle got ig/dg/we/hold %b addr %h exp 0010 020",
               {if_gnt, dm_gnt, mem_we, core_hold}, mem_addr);
    end
    tests_run++;
    if (dm_rvalid !== 1'b1 || dm_rdata !== ref_mem[9]) begin
      tests_failed++;
      $display("FAIL preempt_rvalid got %b %h exp 1 %h", dm_rvalid, dm_rdata, ref_mem[9]);
    end
    ref_mem[32] = 32'hA5A5A5A5;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      set_idle();
      #1;
      tests_run++;
      if (core_hold !== 1'b1) begin
        tests_failed++;
        $display("FAIL preempt_hold%0d got %b exp 1", k, core_hold);
      end
    end
    @(negedge clk);
    flash_en = 1'b1; flash_addr = 32'h84; flash_data = 32'h5A5A5A5A;
    ref_mem[33] = 32'h5A5A5A5A;
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      set_idle();
      #1;
      tests_run++;
      if (core_hold !== ((k < 4) ? 1'b1 : 1'b0)) begin
        tests_failed++;
        $display("FAIL restart_hold%0d got %b exp %b", k, core_hold, (k < 4) ? 1'b1 : 1'b0);
      end
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      set_idle(); if_req = 1'b1; if_addr = 32'h80 + 32'(i * 4);
      #1;
      tests_run++;
      if (if_gnt !== 1'b1) begin
        tests_failed++;
        $display("FAIL flash_run_readback%0d got gnt %b exp 1", i, if_gnt);
      end
      push_read(1'b1, if_addr);
    end
    @(negedge clk);
    set_idle();
  endtask

  task automatic test_reset_mid_read();
    @(negedge clk);
    set_idle(); if_req = 1'b1; if_addr = 32'h84;
    #1;
    tests_run++;
    if (if_gnt !== 1'b1) begin
      tests_failed++;
      $display("FAIL midread_gnt got %b exp 1", if_gnt);
    end
    push_read(1'b1, 32'h84);
    @(negedge clk);
    set_idle(); rst = 1'b0;
    #1;
    tests_run++;
    if ({if_rvalid, core_hold} !== 2'b01) begin
      tests_failed++;
      $display("FAIL midread_kill got rvalid/hold %b exp 01", {if_rvalid, core_hold});
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) begin
      ram[i] = '0;
      ref_mem[i] = '0;
    end
    rst = 1'b0;
    flash_en = 1'b0; flash_addr = '0; flash_data = '0;
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    mon_en = 1'b1;
    test_reset();
    test_flash_during_reset();
    test_contention();
    test_store_load();
    test_alias();
    test_preempt();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-port synchronous instruction/data RAM between three requesters: the external flash programming port, the core's instruction fetch and the core's data load/store unit. It holds the core in reset (`core_hold`) while the memory is being programmed and for a fixed quiet period afterwards. In run mode it arbitrates fetch against load/store with anti-starvation, and returns read data to the requester that issued the read. It sits in `top` between the flash pins, the core and the RAM.

## Interface
- `WIDTH`, 32, data and byte-address width
- `ADDR_WIDTH`, 11, byte-address bits decoded; RAM has 2^(ADDR_WIDTH-2) words
- `HOLD_CYCLES`, 4, consecutive flash-idle cycles before the core is released (≥1)
- `MAX_WAIT`, 4, consecutive denied fetch cycles after which fetch wins (≥1)

- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `flash_en`  in  1  flash write strobe, one word per cycle
- `flash_addr`  in  WIDTH  flash byte address
- `flash_data`  in  WIDTH  flash write data
- `if_req`  in  1  fetch read request
- `if_addr`  in  WIDTH  fetch byte address
- `if_gnt`  out  1  fetch accepted this cycle
- `if_rvalid`  out  1  fetch data valid
- `if_rdata`  out  WIDTH  fetch data
- `dm_req`  in  1  data request
- `dm_we`  in  1  1 = store, 0 = load
- `dm_addr`  in  WIDTH  data byte address
- `dm_wdata`  in  WIDTH  store data
- `dm_gnt`  out  1  data accepted this cycle
- `dm_rvalid`  out  1  load data valid
- `dm_rdata`  out  WIDTH  load data
- `mem_en`  out  1  RAM access enable
- `mem_we`  out  1  RAM write enable
- `mem_addr`  out  ADDR_WIDTH-2  RAM word address
- `mem_wdata`  out  WIDTH  RAM write data
- `mem_rdata`  in  WIDTH  RAM read data, valid the cycle after a read
- `core_hold`  out  1  hold core in reset while 1

## Operation
- Address mapping: `mem_addr = addr[ADDR_WIDTH-1:2]`. Low 2 bits and bits ≥ ADDR_WIDTH are ignored, so out-of-range addresses alias.
- There are two states, PROG and RUN. `rst` low forces PROG, quiet counter 0, wait counter 0 and response owner NONE.
- The flash path is combinational and is honoured in every state, including while `rst` is low. `flash_en=1` drives `mem_en=1`, `mem_we=1`, the flash address and the flash data. Both `if_gnt` and `dm_gnt` are 0 that cycle.
- PROG:
  - `core_hold=1`. No core grants.
  - The quiet counter clears on `flash_en=1` and increments otherwise.
  - When the counter reaches HOLD_CYCLES, the state goes to RUN at the next edge.
- RUN:
  - `core_hold=0`.
  - `flash_en=1` moves the state to PROG at the next edge, with the quiet counter at 0. The flash write in that cycle still preempts both core requests.
- RUN arbitration with no flash write:
  - Default priority is data over fetch.
  - If the wait counter equals MAX_WAIT and `if_req=1`, fetch wins.
  - Exactly one grant is issued per cycle. The granted request drives the `mem_*` outputs.
  - A grant is combinational: `gnt` is asserted in the same cycle as `req`.
  - A requester that is not granted must hold its request and signals. The arbiter keeps no queue.
- Wait counter:
  - Increments while `if_req=1 && !if_gnt` in RUN, saturating at MAX_WAIT.
  - Clears on `if_gnt`, on `if_req=0`, and in PROG.
- Reads:
  - A granted read registers its owner (IF or DM). The next cycle pulses that requester's `rvalid` for one cycle, with `rdata = mem_rdata`.
  - A store or flash write registers owner NONE.
  - The pending response from the cycle before a flash preemption is still delivered.
- Both `rdata` outputs continuously mirror `mem_rdata`. Only `rvalid` qualifies them.

## Timing
- Output values while `rst` is low:
  - `core_hold=1`, `if_gnt=0`, `dm_gnt=0`, `if_rvalid=0`, `dm_rvalid=0`.
  - The `mem_*` outputs follow the flash port; all are 0 when `flash_en=0`.
- After `rst` rises, `core_hold` falls after HOLD_CYCLES cycles with `flash_en=0`, i.e. at edge HOLD_CYCLES.
- A flash write issued in the cycle where the counter is HOLD_CYCLES−1 restarts the count.
- Grant latency is 0 cycles. Read data latency is 1 cycle after the grant.
- Back-to-back reads every cycle are sustained, with one response per cycle.
- Fetch is guaranteed a grant within MAX_WAIT+1 cycles of continuous `if_req` in RUN, absent flash writes.
- A `rst` fall mid-read kills the pending `rvalid` immediately.

## Test plan
- **Flash during reset:** write 0x02802783@0, 0x00000005@36 and 0x0000006f@16 while `rst` is low. Then release reset and read back via fetch.
  - Required: exact words returned, one cycle after each grant.
  - Required: `core_hold` falls exactly 4 cycles after the last `flash_en` or `rst` release.
- **Contention:** hold `if_req` and `dm_req` (load) together for 10 cycles.
  - Required: dm granted 4 cycles, if granted the 5th, dm 4, if 1.
  - Required: each `rvalid` is routed to its correct owner.
- **Flash preemption in RUN:** `flash_en` asserted while dm is reading 36.
  - Required: no gnt that cycle.
  - Required: the previous cycle's `dm_rvalid` is still delivered.
  - Required: `core_hold=1` from the next edge, and 0 again after 4 idle cycles.
- **Store/load:** store 0xDEADBEEF to 0x40, then load 0x40.
  - Required: no `rvalid` for the store.
  - Required: `dm_rdata=0xDEADBEEF` one cycle after the load grant.
- **Aliasing:** fetch from 0x804 and from 0x004 with ADDR_WIDTH=11.
  - Required: both return the same word, with `mem_addr=1`.
- **Reset mid-read:** `rst` low in the cycle after a granted fetch read.
  - Required: `if_rvalid=0` immediately, and `core_hold=1`.
